src_serial_arbiter: RTL and testbench
=====================================

Name: src_serial_arbiter

Overview:
- Shares one serial probe source path (a chain of single-bit source registers) between N_REQ parallel-word requesters.
- Each cycle in IDLE, round-robin arbitration picks one requester and accepts its word over a valid/ready handshake.
- The accepted word is shifted out MSB-first on ser_data with a framing strobe; a programmable gap follows each frame.
- Sits between the probe capture clients and the source-register chain input.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 8, bits per word (>=2).
- IDLE_GAP, 1, cycles with ser_frame low inserted after each frame (0..15).
- ID_W, 2, width of ser_id (must be >= clog2(N_REQ)).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester word valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- req_data  in  N_REQ*DATA_W  requester i word at [i*DATA_W +: DATA_W].
- ser_data  out  1  serial bit to source chain, registered.
- ser_frame  out  1  high while ser_data carries a valid frame bit, registered.
- ser_id  out  ID_W  index of requester owning current/last frame, registered.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (async, rst_n low): state=IDLE, ser_data=0, ser_frame=0, ser_id=0, shift reg=0, bit counter=0, gap counter=0, rr pointer=N_REQ-1 (first priority goes to requester 0). busy=0, req_ready=0 while rst_n low.
- States: IDLE, SHIFT, GAP.
- IDLE arbitration:
  - Combinational round-robin search starting at pointer+1 mod N_REQ, over req_valid.
  - req_ready[g]=1 only for the winner g, and only in IDLE.
  - A handshake completes on any edge with req_valid[g] && req_ready[g].
- Accept edge:
  - shreg <= word g.
  - ser_data <= word[DATA_W-1], ser_frame <= 1, ser_id <= g, pointer <= g.
  - Bit counter <= DATA_W-1; go to SHIFT.
- SHIFT:
  - Each edge with counter > 0: ser_data <= next lower bit; counter decrements.
  - Edge with counter == 0: ser_frame <= 0, ser_data <= 0.
  - Then go to GAP (gap counter <= IDLE_GAP-1) if IDLE_GAP > 0, else to IDLE.
- GAP: decrement each edge; at 0, go to IDLE.
- Timing:
  - ser_frame is high for exactly DATA_W consecutive cycles, starting the cycle after the accept edge.
  - Minimum spacing between frame starts is DATA_W+1+IDLE_GAP cycles, since ready is issued only in IDLE.
- req_ready is never asserted in SHIFT or GAP. Changes to req_valid/req_data there are ignored; the word is captured only at the accept edge.
- Requesters hold valid until ready. The arbiter tolerates valid being withdrawn before accept (no grant is latched without a handshake).
- Fairness: a requester with valid held is served within N_REQ frames.
- If no requester is valid in IDLE, stay in IDLE with outputs held (ser_frame=0, ser_data=0, ser_id unchanged).
- Reset mid-frame: the frame is abandoned immediately (ser_frame=0). The accepted word is lost and is not retried.

Test Plan:
- Single request: N_REQ=4, DATA_W=8, IDLE_GAP=1; req_valid=0001, data0=8'hA5 → req_ready=0001 for one cycle. Next 8 cycles: ser_frame=1, ser_data=1,0,1,0,0,1,0,1, ser_id=0. Then busy for 1 gap cycle, then IDLE.
- Round-robin: req_valid=1111 held, words 8'h01/02/03/04 → grants in order 0,1,2,3,0. Frame starts are 10 cycles apart. ser_id follows the grant order.
- Pointer skip: after serving 1, req_valid=0011 → grant 0 is skipped until 2/3 are checked; next grant is 0, then 1.
- IDLE_GAP=0: two valid requesters → ser_frame low exactly 1 cycle between frames; starts are 9 cycles apart.
- Async reset at bit 4 of a frame → ser_frame/ser_data drop to 0 with no clock edge. After release, requester 0 has priority and a held request re-handshakes.
- Busy-time changes: data0 changed and req_valid toggled during SHIFT → transmitted bits equal the word captured at accept; req_ready stays 0 throughout SHIFT/GAP.

Source files
------------

// File: rtl/src_serial_arbiter.sv
// Round-robin arbiter that serialises one requester word at a time onto a
// single-bit source chain input: MSB-first data, framing strobe, owner id.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   req_valid/ready    per-requester handshake (ready one-hot, IDLE only)
//   req_data           requester i word at [i*DATA_W +: DATA_W]
//   ser_data/frame/id  registered serial bit, frame strobe, owner index
//   busy               high whenever a frame or its gap is in progress
module src_serial_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int IDLE_GAP = 1,
  parameter int ID_W     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic                    ser_data,
  output logic                    ser_frame,
  output logic [ID_W-1:0]         ser_id,
  output logic                    busy
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_TOP = CW'(DATA_W - 1);
  localparam logic [3:0] GAP_TOP =
    (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        gap_q, gap_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              sd_q, sd_d;
  logic              sf_q, sf_d;

  logic              gnt_vld;
  logic [ID_W-1:0]   gnt_idx;
  logic [DATA_W-1:0] gnt_word;
  logic              hs;

  // Search starts one past the last winner, so the last winner
  // has lowest priority on the next round.
  always_comb begin
    int j;
    j = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(ptr_q) + k) % N_REQ;
      if (!gnt_vld && req_valid[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = ID_W'(j);
      end
    end
  end

  assign gnt_word =
    req_data[int'(gnt_idx)*DATA_W +: DATA_W];

  // rst_n gates ready so nothing is offered
  // while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == S_IDLE && gnt_vld)
      req_ready[gnt_idx] = 1'b1;
  end

  assign hs = |(req_valid & req_ready);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    sd_d    = sd_q;
    sf_d    = sf_q;
    unique case (state_q)
      S_IDLE: begin
        sd_d = 1'b0;
        sf_d = 1'b0;
        if (hs) begin
          shreg_d = gnt_word;
          sd_d    = gnt_word[DATA_W-1];
          sf_d    = 1'b1;
          id_d    = gnt_idx;
          ptr_d   = gnt_idx;
          cnt_d   = CNT_TOP;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          // MSB already on the wire; next bit sits below it.
          sd_d    = shreg_q[DATA_W-2];
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - CW'(1);
        end else begin
          sd_d = 1'b0;
          sf_d = 1'b0;
          if (IDLE_GAP > 0) begin
            gap_d   = GAP_TOP;
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else gap_d = gap_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      ptr_q   <= ID_W'(N_REQ - 1);
      id_q    <= '0;
      sd_q    <= 1'b0;
      sf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sd_q    <= sd_d;
      sf_q    <= sf_d;
    end
  end

  assign ser_data  = sd_q;
  assign ser_frame = sf_q;
  assign ser_id    = id_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_src_serial_arbiter.sv
// Bench for src_serial_arbiter: two instances (gap 1 and gap 0)
// checked each cycle against a frame-timeline model plus literals.
module tb_src_serial_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0][3:0]  valid;
  logic [1:0][31:0] data;
  logic [1:0][3:0]  rdy;
  logic [1:0]       sd, sf, bsy;
  logic [1:0][1:0]  sid;

  always #5 clk = ~clk;

  src_serial_arbiter #(
    .N_REQ(4), .DATA_W(8), .IDLE_GAP(1), .ID_W(2)
  ) u_dut_g1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(valid[0]), .req_ready(rdy[0]),
    .req_data(data[0]),
    .ser_data(sd[0]), .ser_frame(sf[0]),
    .ser_id(sid[0]), .busy(bsy[0])
  );

  src_serial_arbiter #(
    .N_REQ(4), .DATA_W(8), .IDLE_GAP(0), .ID_W(2)
  ) u_dut_g0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(valid[1]), .req_ready(rdy[1]),
    .req_data(data[1]),
    .ser_data(sd[1]), .ser_frame(sf[1]),
    .ser_id(sid[1]), .busy(bsy[1])
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit [1:0] oneshot = 2'b01;
  logic [1:0][3:0] pend = '0;

  // model: cycles since accept, last owner, rr pointer, word
  int m_t[2];
  int m_ptr[2];
  int m_id[2];
  logic [7:0] m_word[2];

  // frame log
  int nfr[2] = '{0, 0};
  logic [7:0] fw[2][32];
  int fid[2][32];
  int fst[2][32];
  int flen[2][32];
  int lowrun[2][32];
  logic [1:0] pf = '0;
  logic [7:0] acc[2];
  int bc[2] = '{0, 0};
  int lowcnt[2] = '{0, 0};
  int rdy0_cnt = 0;
  int viol = 0;

  function automatic int gap_of(int c);
    return (c == 0) ? 1 : 0;
  endfunction

  function automatic int rr_pick(logic [3:0] v, int ptr);
    for (int k = 1; k <= 4; k++)
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  // A frame occupies 8 cycles, then gap cycles; idle after that.
  always @(posedge clk or negedge rst_n) begin
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        m_t[c]    <= 8 + gap_of(c);
        m_ptr[c]  <= 3;
        m_id[c]   <= 0;
        m_word[c] <= 8'h00;
      end else if (m_t[c] >= 8 + gap_of(c)) begin
        if (rr_pick(valid[c], m_ptr[c]) >= 0) begin
          m_word[c] <=
            data[c][rr_pick(valid[c], m_ptr[c])*8 +: 8];
          m_id[c]  <= rr_pick(valid[c], m_ptr[c]);
          m_ptr[c] <= rr_pick(valid[c], m_ptr[c]);
          m_t[c]   <= 0;
        end
      end else begin
        m_t[c] <= m_t[c] + 1;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    int w;
    logic idle, ef, ed, eb;
    logic [3:0] er;
    @(negedge clk);
    cyc++;
    for (int c = 0; c < 2; c++) begin
      idle = (m_t[c] >= 8 + gap_of(c));
      w = rr_pick(valid[c], m_ptr[c]);
      er = (rst_n && idle && w >= 0) ? 4'(1 << w) : 4'd0;
      ef = (m_t[c] < 8);
      ed = ef ? m_word[c][7 - m_t[c]] : 1'b0;
      eb = !idle;
      n_chk++;
      if (rdy[c] !== er || sf[c] !== ef || sd[c] !== ed ||
          sid[c] !== 2'(m_id[c]) || bsy[c] !== eb) begin
        n_fail++;
        $display({"FAIL cycle %0d ch%0d rdy/frm/dat/id/busy",
                  " got %b/%b/%b/%0d/%b want %b/%b/%b/%0d/%b"},
                 cyc, c, rdy[c], sf[c], sd[c], sid[c], bsy[c],
                 er, ef, ed, m_id[c], eb);
      end
      pend[c] = valid[c] & rdy[c];
      if (bsy[c] && |rdy[c]) viol++;
      if (c == 0 && rdy[0][0]) rdy0_cnt++;
      if (sf[c]) begin
        if (!pf[c]) begin
          if (nfr[c] < 32) begin
            fst[c][nfr[c]]    = cyc;
            fid[c][nfr[c]]    = int'(sid[c]);
            lowrun[c][nfr[c]] = lowcnt[c];
          end
          nfr[c]++;
          acc[c] = 8'h00;
          bc[c]  = 0;
        end
        acc[c] = {acc[c][6:0], sd[c]};
        bc[c]++;
      end else begin
        if (pf[c] && nfr[c] > 0 && nfr[c] <= 32) begin
          fw[c][nfr[c]-1]   = acc[c];
          flen[c][nfr[c]-1] = bc[c];
        end
        if (pf[c]) lowcnt[c] = 0;
        lowcnt[c]++;
      end
      pf[c] = sf[c];
    end
    @(posedge clk);
    #2;
    for (int c = 0; c < 2; c++)
      if (oneshot[c]) valid[c] = valid[c] & ~pend[c];
  endtask

  task automatic wait_frames(int c, int n, int budget,
                             string nm);
    int k;
    k = 0;
    while (nfr[c] < n && k < budget) begin
      tick();
      k++;
    end
    n_chk++;
    if (nfr[c] < n) begin
      n_fail++;
      $display("FAIL %s: timeout, frames %0d wanted %0d",
               nm, nfr[c], n);
    end
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int b;
    int exp_id[5];
    valid = '0;
    data  = '0;
    // test 1: single request A5, valid already up in reset
    valid[0] = 4'b0001;
    data[0]  = 32'h0000_00A5;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", 32'(rdy[0]), 32'h0);
    chk("rst_frame", 32'(sf[0]), 32'h0);
    chk("rst_data", 32'(sd[0]), 32'h0);
    chk("rst_id", 32'(sid[0]), 32'h0);
    chk("rst_busy", 32'(bsy[0]), 32'h0);
    #14 rst_n = 1'b1;
    wait_frames(0, 1, 20, "t1_start");
    repeat (12) tick();
    chk("t1_word", 32'(fw[0][0]), 32'hA5);
    chk("t1_id", 32'(fid[0][0]), 32'h0);
    chk("t1_len", 32'(flen[0][0]), 32'd8);
    chk("t1_ready_cycles", 32'(rdy0_cnt), 32'd1);

    // test 2: all four held, from reset
    oneshot[0] = 1'b0;
    data[0]  = 32'h0403_0201;
    valid[0] = 4'b1111;
    pulse_reset();
    b = nfr[0];
    wait_frames(0, b + 5, 80, "t2_frames");
    valid[0] = 4'b0000;
    repeat (12) tick();
    exp_id = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      chk("t2_id", 32'(fid[0][b+k]), 32'(exp_id[k]));
      chk("t2_word", 32'(fw[0][b+k]), 32'(exp_id[k] + 1));
      if (k > 0) begin
        chk("t2_spacing",
            32'(fst[0][b+k] - fst[0][b+k-1]), 32'd10);
        chk("t2_lowrun", 32'(lowrun[0][b+k]), 32'd2);
      end
    end

    // test 3: serve 1, then 0 and 1 together
    oneshot[0] = 1'b1;
    data[0]  = 32'h0000_2211;
    valid[0] = 4'b0010;
    b = nfr[0];
    wait_frames(0, b + 1, 30, "t3_first");
    valid[0] = 4'b0011;
    wait_frames(0, b + 3, 60, "t3_rest");
    repeat (12) tick();
    chk("t3_id0", 32'(fid[0][b]), 32'd1);
    chk("t3_id1", 32'(fid[0][b+1]), 32'd0);
    chk("t3_id2", 32'(fid[0][b+2]), 32'd1);
    chk("t3_w1", 32'(fw[0][b+1]), 32'h11);
    chk("t3_w2", 32'(fw[0][b+2]), 32'h22);

    // test 4: data and valid change while shifting
    data[0]  = 32'h0000_00A5;
    valid[0] = 4'b0001;
    b = nfr[0];
    wait_frames(0, b + 1, 30, "t4_start");
    data[0] = 32'h0000_003C;
    tick();
    valid[0] = 4'b0000;
    tick();
    valid[0] = 4'b0001;
    data[0]  = 32'h0000_00FF;
    tick();
    valid[0] = 4'b0000;
    data[0]  = 32'h0000_0000;
    tick();
    repeat (12) tick();
    chk("t4_word", 32'(fw[0][b]), 32'hA5);
    chk("t4_len", 32'(flen[0][b]), 32'd8);

    // test 5: async reset on bit 4 of 0F (a one)
    oneshot[0] = 1'b0;
    data[0]  = 32'h0000_770F;
    valid[0] = 4'b0001;
    b = nfr[0];
    wait_frames(0, b + 1, 30, "t5_start");
    repeat (3) tick();
    #1;
    chk("t5_pre_data", 32'(sd[0]), 32'h1);
    chk("t5_pre_frame", 32'(sf[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_frame", 32'(sf[0]), 32'h0);
    chk("t5_rst_data", 32'(sd[0]), 32'h0);
    chk("t5_rst_busy", 32'(bsy[0]), 32'h0);
    chk("t5_rst_ready", 32'(rdy[0]), 32'h0);
    valid[0] = 4'b0011;
    tick();
    rst_n = 1'b1;
    wait_frames(0, b + 2, 30, "t5_after");
    valid[0] = 4'b0000;
    repeat (12) tick();
    chk("t5_id", 32'(fid[0][b+1]), 32'd0);
    chk("t5_word", 32'(fw[0][b+1]), 32'h0F);

    // test 6: zero gap instance, two requesters
    oneshot[1] = 1'b1;
    data[1]  = 32'h0000_C35A;
    valid[1] = 4'b0011;
    wait_frames(1, 2, 40, "t6_frames");
    repeat (12) tick();
    chk("t6_id0", 32'(fid[1][0]), 32'd0);
    chk("t6_id1", 32'(fid[1][1]), 32'd1);
    chk("t6_w0", 32'(fw[1][0]), 32'h5A);
    chk("t6_w1", 32'(fw[1][1]), 32'hC3);
    chk("t6_spacing", 32'(fst[1][1] - fst[1][0]), 32'd9);
    chk("t6_lowrun", 32'(lowrun[1][1]), 32'd1);

    chk("ready_in_busy", 32'(viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
